// File: rtl/round_key_server.sv
// Round-key server: captures a 256-bit key bundle and hands out one 32-bit round key
// per handshake, in forward or reverse order, zeroizing the store when the sequence ends.
module round_key_server #(
    parameter int NUM_KEYS = 8,
    parameter int KEY_W    = 32,
    parameter int ROUNDS   = 8,
    localparam int RW      = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [NUM_KEYS*KEY_W-1:0] load_keys,
    input  logic                      load_decrypt,
    input  logic                      abort,
    output logic                      key_valid,
    input  logic                      key_ready,
    output logic [KEY_W-1:0]          key_out,
    output logic [RW-1:0]             key_round,
    output logic                      done
);

    localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    if (ROUNDS <= 0 || (ROUNDS % NUM_KEYS) != 0) begin : g_bad_rounds
        $error("round_key_server: ROUNDS must be a positive multiple of NUM_KEYS");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [KEY_W-1:0]  key_mem [NUM_KEYS];
    logic [RW-1:0]     round_cnt;
    logic              dir;
    logic              last_round;
    logic              load_fire;
    logic              advance;
    logic              finish;
    logic              clear;
    logic [IW-1:0]     fwd_idx;
    logic [IW-1:0]     key_idx;

    // Control: abort outranks both a pending load and a key handshake.
    always_comb begin
        state_nxt  = state;
        load_fire  = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        clear      = 1'b0;
        last_round = (round_cnt == RW'(ROUNDS - 1));
        case (state)
            IDLE: begin
                if (!abort && load_valid) begin
                    load_fire = 1'b1;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (abort) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end else if (key_ready) begin
                    if (last_round) begin
                        finish    = 1'b1;
                        clear     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Key store, round counter and direction; cleared on completion or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            round_cnt <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (load_fire) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    key_mem[i] <= load_keys[(NUM_KEYS-1-i)*KEY_W +: KEY_W];
                end
                dir       <= load_decrypt;
                round_cnt <= '0;
            end else if (clear) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    key_mem[i] <= '0;
                end
                dir       <= 1'b0;
                round_cnt <= '0;
            end else if (advance) begin
                round_cnt <= round_cnt + RW'(1);
            end
        end
    end

    // Output select: K0 sits at the top of the bundle, reverse order mirrors the index.
    always_comb begin
        fwd_idx = IW'(int'(round_cnt) % NUM_KEYS);
        key_idx = dir ? (IW'(NUM_KEYS - 1) - fwd_idx) : fwd_idx;
    end

    assign load_ready = (state == IDLE);
    assign key_valid  = (state == SERVE);
    assign key_out    = key_valid ? key_mem[key_idx] : '0;
    assign key_round  = round_cnt;

endmodule
